// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame geometry.
// The TX block imports the same package.
package svc_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/svc_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// RESET_VAL lets an idle-high line come out of reset without a false edge.
module svc_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line at the clock rate,
// samples mid-bit, and hands complete bytes out over a valid/ready holding register.
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      urx_rx,
  output logic                      urx_valid,
  output logic [UART_DATA_BITS-1:0] urx_data,
  input  logic                      urx_ready,
  output logic                      urx_frame_err,
  output logic                      urx_overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  // Fewer than 4 clocks per bit leaves no usable mid-bit sample point.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("svc_uart_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rx_s;

  svc_sync #(
    .STAGES   (2),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(urx_rx),
    .q_o(rx_s)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      stop_ok;
  logic                      accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    stop_ok     = 1'b0;
    accept      = valid_q && urx_ready;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // Leaving at mid stop bit lets a gapless next start be caught.
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (stop_ok) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign urx_valid     = valid_q;
  assign urx_data      = data_q;
  assign urx_frame_err = frame_err_q;
  assign urx_overrun   = overrun_q;

endmodule

// File: tb/tb_svc_uart_rx.sv
// Directed bench for svc_uart_rx at 10 clocks per bit.
module tb_svc_uart_rx;
  import svc_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       urx_rx;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready;
  logic       urx_frame_err;
  logic       urx_overrun;

  svc_uart_rx #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .urx_rx       (urx_rx),
    .urx_valid    (urx_valid),
    .urx_data     (urx_data),
    .urx_ready    (urx_ready),
    .urx_frame_err(urx_frame_err),
    .urx_overrun  (urx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         t;
  } rx_ev_t;

  rx_ev_t rx_q[$];
  int     fe_cnt = 0;
  int     ov_cnt = 0;
  int     checks = 0;
  int     passed = 0;

  // Record accepted bytes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (urx_valid && urx_ready) rx_q.push_back('{d: urx_data, t: cyc});
      if (urx_frame_err) fe_cnt++;
      if (urx_overrun) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level so frames can run back to back.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    urx_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      urx_rx = b[i];
      tick(10);
    end
    urx_rx = stop_bit;
    tick(10);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp, output int t);
    rx_ev_t ev;
    t = -1;
    check({tag, "_present"}, 32'(rx_q.size() > 0), 32'd1);
    if (rx_q.size() > 0) begin
      ev = rx_q.pop_front();
      t  = ev.t;
      check({tag, "_data"}, 32'(ev.d), 32'(exp));
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    int fe0, ov0;

    rst       = 1'b1;
    urx_rx    = 1'b1;
    urx_ready = 1'b1;
    tick(3);
    check("rst_valid", 32'(urx_valid), 32'd0);
    check("rst_data", 32'(urx_data), 32'h00);
    check("rst_fe", 32'(urx_frame_err), 32'd0);
    check("rst_ov", 32'(urx_overrun), 32'd0);
    rst = 1'b0;
    tick(5);

    // 1: single byte, latency from start edge
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(5);
    check("t1_count", 32'(rx_q.size()), 32'd1);
    expect_byte("t1", 8'hA5, t1);
    check("t1_latency", 32'(t1 - t0), 32'd98);
    check("t1_fe", 32'(fe_cnt), 32'd0);
    check("t1_ov", 32'(ov_cnt), 32'd0);
    check("t1_valid_low", 32'(urx_valid), 32'd0);
    $display("t1 sent 0xA5 latency %0d", t1 - t0);

    // 2: three gapless frames
    tick(20);
    t0 = cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(5);
    check("t2_count", 32'(rx_q.size()), 32'd3);
    expect_byte("t2_b0", 8'h00, t1);
    expect_byte("t2_b1", 8'hFF, t2);
    expect_byte("t2_b2", 8'h55, t3);
    check("t2_lat0", 32'(t1 - t0), 32'd98);
    check("t2_gap01", 32'(t2 - t1), 32'd100);
    check("t2_gap12", 32'(t3 - t2), 32'd100);
    $display("t2 sent 00 FF 55 gaps %0d %0d", t2 - t1, t3 - t2);

    // 3: overrun while holding register full
    tick(20);
    ov0 = ov_cnt;
    urx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    tick(7);
    check("t3_valid_held", 32'(urx_valid), 32'd1);
    send_frame(8'hC3, 1'b1);
    tick(5);
    check("t3_valid", 32'(urx_valid), 32'd1);
    check("t3_data_kept", 32'(urx_data), 32'h3C);
    check("t3_overrun", 32'(ov_cnt - ov0), 32'd1);
    check("t3_none_taken", 32'(rx_q.size()), 32'd0);
    urx_ready = 1'b1;
    tick(1);
    check("t3_valid_clr", 32'(urx_valid), 32'd0);
    expect_byte("t3", 8'h3C, t1);
    tick(20);
    check("t3_count_after", 32'(rx_q.size()), 32'd0);
    $display("t3 sent 3C C3 with ready low, overruns %0d", ov_cnt - ov0);

    // 4: framing error with line held low, then recovery
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0);
    tick(20);
    urx_rx = 1'b1;
    tick(20);
    check("t4_fe", 32'(fe_cnt - fe0), 32'd1);
    check("t4_no_byte", 32'(rx_q.size()), 32'd0);
    check("t4_valid", 32'(urx_valid), 32'd0);
    send_frame(8'h42, 1'b1);
    tick(5);
    expect_byte("t4", 8'h42, t1);
    check("t4_fe_after", 32'(fe_cnt - fe0), 32'd1);
    $display("t4 sent 0x81 bad stop then 0x42");

    // 5: short low glitch on idle line
    tick(20);
    fe0 = fe_cnt;
    urx_rx = 1'b0;
    tick(3);
    urx_rx = 1'b1;
    tick(20);
    check("t5_no_byte", 32'(rx_q.size()), 32'd0);
    check("t5_fe", 32'(fe_cnt - fe0), 32'd0);
    check("t5_idle", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h7E, 1'b1);
    tick(5);
    expect_byte("t5", 8'h7E, t1);
    check("t5_data_out", 32'(urx_data), 32'h7E);
    $display("t5 glitch then 0x7E");

    // 6: reset in the middle of a data bit
    tick(20);
    fork
      send_frame(8'h99, 1'b1);
      begin
        tick(53);
        rst = 1'b1;
        tick(1);
        check("t6_rst_valid", 32'(urx_valid), 32'd0);
        check("t6_rst_data", 32'(urx_data), 32'h00);
        check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
      end
    join
    tick(3);
    check("t6_rst_data2", 32'(urx_data), 32'h00);
    check("t6_rst_fe", 32'(urx_frame_err), 32'd0);
    rst = 1'b0;
    tick(10);
    send_frame(8'h11, 1'b1);
    tick(5);
    check("t6_count", 32'(rx_q.size()), 32'd1);
    expect_byte("t6", 8'h11, t1);
    $display("t6 reset mid frame then 0x11");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
